// File: rtl/stack_pkg.sv
// Shared definitions for the stack controller / stack RAM pair.
// Word and address widths plus the responder's state encoding.
package stack_pkg;

  localparam int STACK_DATA_W = 8;
  localparam int STACK_ADDR_W = 8;

  typedef logic [0:0] state_t;

  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

  // Legal read pipeline depths for the responder.
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;

endpackage

// File: rtl/ram_read_pipe.sv
// Read-data pipeline for the stack RAM: a chain of {valid,data} stages.
// The last stage only reloads on a valid word so the output holds between reads.
module ram_read_pipe #(
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  valid_reg [READ_LATENCY];
  logic [DATA_WIDTH-1:0] data_reg  [READ_LATENCY];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        valid_reg[i] <= 1'b0;
        data_reg[i]  <= '0;
      end
    end else begin
      valid_reg[0] <= in_valid;
      // Stage 0 is also the output stage when the latency is 1.
      if (READ_LATENCY > 1 || in_valid) begin
        data_reg[0] <= in_data;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_reg[i] <= valid_reg[i-1];
        if (i < READ_LATENCY - 1 || valid_reg[i-1]) begin
          data_reg[i] <= data_reg[i-1];
        end
      end
    end
  end

  assign out_valid = valid_reg[READ_LATENCY-1];
  assign out_data  = data_reg[READ_LATENCY-1];

endmodule

// File: rtl/stack_ram_responder.sv
// Single-port synchronous RAM answering a stack controller, with a post-reset
// zero-fill sequence, a configurable read pipeline and a read-valid strobe.
module stack_ram_responder
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH     = STACK_DATA_W,
  parameter int ADDR_WIDTH     = STACK_ADDR_W,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter bit WRITE_FIRST    = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  RAMEnable,
  input  logic                  RAMWriteEnable,
  input  logic [ADDR_WIDTH-1:0] RAMAddress,
  input  logic [DATA_WIDTH-1:0] RAMDataIn,
  output logic [DATA_WIDTH-1:0] RAMDataOut,
  output logic                  RAMReadValid,
  output logic                  Busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state_reg;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr_reg;

  logic                  clearing;
  logic                  ready;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  launch;
  logic [DATA_WIDTH-1:0] launch_word;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: the clear sweep ends on the edge that writes DEPTH-1.
  always_comb begin
    state_next = state_reg;
    if (state_reg == ST_CLEAR && clr_ptr_reg == {ADDR_WIDTH{1'b1}}) begin
      state_next = ST_READY;
    end
  end

  // Output logic
  always_comb begin
    clearing = (state_reg == ST_CLEAR);
    ready    = (state_reg == ST_READY);
    Busy     = clearing;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clr_ptr_reg <= '0;
    end else if (clearing) begin
      clr_ptr_reg <= clr_ptr_reg + ADDR_WIDTH'(1);
    end
  end

  // Single write port shared between the zero-fill sweep and the controller.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = RAMAddress;
    wr_data = RAMDataIn;
    if (clearing) begin
      wr_en   = 1'b1;
      wr_addr = clr_ptr_reg;
      wr_data = '0;
    end else if (ready && RAMEnable && RAMWriteEnable) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_en && !Reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Every enabled access launches a read; a write may forward its own data.
  always_comb begin
    launch      = ready && RAMEnable;
    launch_word = mem[RAMAddress];
    if (WRITE_FIRST && RAMWriteEnable) begin
      launch_word = RAMDataIn;
    end
  end

  ram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_read_pipe (
    .Clk      (Clk),
    .Reset    (Reset),
    .in_valid (launch),
    .in_data  (launch_word),
    .out_valid(RAMReadValid),
    .out_data (RAMDataOut)
  );

endmodule

// File: tb/tb_stack_ram_responder.sv
// Three responder configurations share one stimulus stream; each is checked
// every cycle against a memory-plus-due-time scoreboard model.
module tb_stack_ram_responder;
  import stack_pkg::*;

  localparam int NDUT  = 3;
  localparam int DW    = STACK_DATA_W;
  localparam int DEPTH = 2 ** STACK_ADDR_W;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          RAMEnable = 1'b0;
  logic          RAMWriteEnable = 1'b0;
  logic [7:0]    RAMAddress = '0;
  logic [DW-1:0] RAMDataIn = '0;

  logic [DW-1:0] out_a, out_b, out_c;
  logic          valid_a, valid_b, valid_c;
  logic          busy_a, busy_b, busy_c;

  logic [DW-1:0] dout   [NDUT];
  logic          dvalid [NDUT];
  logic          dbusy  [NDUT];

  assign dout[0] = out_a;   assign dout[1] = out_b;   assign dout[2] = out_c;
  assign dvalid[0] = valid_a; assign dvalid[1] = valid_b; assign dvalid[2] = valid_c;
  assign dbusy[0] = busy_a; assign dbusy[1] = busy_b; assign dbusy[2] = busy_c;

  always #5 Clk = ~Clk;

  stack_ram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(1),
                        .CLEAR_ON_RESET(1'b1), .WRITE_FIRST(1'b0)) dut_a (
    .Clk(Clk), .Reset(Reset), .RAMEnable(RAMEnable), .RAMWriteEnable(RAMWriteEnable),
    .RAMAddress(RAMAddress), .RAMDataIn(RAMDataIn), .RAMDataOut(out_a),
    .RAMReadValid(valid_a), .Busy(busy_a));

  stack_ram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(3),
                        .CLEAR_ON_RESET(1'b1), .WRITE_FIRST(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset), .RAMEnable(RAMEnable), .RAMWriteEnable(RAMWriteEnable),
    .RAMAddress(RAMAddress), .RAMDataIn(RAMDataIn), .RAMDataOut(out_b),
    .RAMReadValid(valid_b), .Busy(busy_b));

  stack_ram_responder #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .READ_LATENCY(2),
                        .CLEAR_ON_RESET(1'b0), .WRITE_FIRST(1'b0)) dut_c (
    .Clk(Clk), .Reset(Reset), .RAMEnable(RAMEnable), .RAMWriteEnable(RAMWriteEnable),
    .RAMAddress(RAMAddress), .RAMDataIn(RAMDataIn), .RAMDataOut(out_c),
    .RAMReadValid(valid_c), .Busy(busy_c));

  // Reference model
  int      lat     [NDUT];
  bit      clr_cfg [NDUT];
  bit      wf_cfg  [NDUT];
  logic [DW-1:0] mmem   [NDUT][DEPTH];
  bit            mknown [NDUT][DEPTH];
  int            busy_left [NDUT];
  bit            sb_v [NDUT][8];
  logic [DW-1:0] sb_d [NDUT][8];
  bit            sb_k [NDUT][8];
  logic [DW-1:0] exp_out   [NDUT];
  bit            exp_out_k [NDUT];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit verbose = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic rst, input logic en, input logic we,
                            input logic [7:0] a, input logic [DW-1:0] d);
    int slot;
    for (int i = 0; i < NDUT; i++) begin
      if (rst) begin
        busy_left[i] = clr_cfg[i] ? DEPTH : 0;
        for (int s = 0; s < 8; s++) sb_v[i][s] = 1'b0;
        exp_out[i]   = '0;
        exp_out_k[i] = 1'b1;
      end else if (busy_left[i] > 0) begin
        mmem[i][DEPTH - busy_left[i]]   = '0;
        mknown[i][DEPTH - busy_left[i]] = 1'b1;
        busy_left[i]--;
      end else if (en) begin
        slot = (cyc + lat[i] - 1) % 8;
        sb_v[i][slot] = 1'b1;
        if (we && wf_cfg[i]) begin
          sb_d[i][slot] = d;
          sb_k[i][slot] = 1'b1;
        end else begin
          sb_d[i][slot] = mmem[i][a];
          sb_k[i][slot] = mknown[i][a];
        end
        if (we) begin
          mmem[i][a]   = d;
          mknown[i][a] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int  slot;
    bit  exp_valid;
    slot = cyc % 8;
    for (int i = 0; i < NDUT; i++) begin
      exp_valid = 1'b0;
      if (sb_v[i][slot]) begin
        exp_valid    = 1'b1;
        exp_out[i]   = sb_d[i][slot];
        exp_out_k[i] = sb_k[i][slot];
        sb_v[i][slot] = 1'b0;
      end
      check_eq($sformatf("busy%0d", i), 32'(dbusy[i]), 32'(busy_left[i] > 0));
      check_eq($sformatf("valid%0d", i), 32'(dvalid[i]), 32'(exp_valid));
      if (exp_out_k[i]) check_eq($sformatf("data%0d", i), 32'(dout[i]), 32'(exp_out[i]));
    end
  endtask

  task automatic do_cycle(input logic rst, input logic en, input logic we,
                          input logic [7:0] a, input logic [DW-1:0] d);
    Reset = rst; RAMEnable = en; RAMWriteEnable = we; RAMAddress = a; RAMDataIn = d;
    @(posedge Clk);
    model_edge(rst, en, we, a, d);
    #1;
    check_outputs();
    if (verbose)
      $display("cyc %0d rst=%0b en=%0b we=%0b addr=%02h din=%02h | a:%02h/%0b b:%02h/%0b c:%02h/%0b",
               cyc, rst, en, we, a, d, out_a, valid_a, out_b, valid_b, out_c, valid_c);
    cyc++;
  endtask

  task automatic rand_cycle();
    logic [7:0] a;
    a = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
    do_cycle(1'b0, $urandom_range(0, 3) != 0, 1'($urandom), a, DW'($urandom));
  endtask

  task automatic count_busy(input string tag);
    int n = 0;
    while (dbusy[0] && n < 400) begin
      rand_cycle();
      n++;
    end
    check_eq(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit busy_c_seen = 1'b0;
    lat[0] = 1; clr_cfg[0] = 1'b1; wf_cfg[0] = 1'b0;
    lat[1] = 3; clr_cfg[1] = 1'b1; wf_cfg[1] = 1'b1;
    lat[2] = 2; clr_cfg[2] = 1'b0; wf_cfg[2] = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      busy_left[i] = 0; exp_out[i] = '0; exp_out_k[i] = 1'b0;
      for (int s = 0; s < 8; s++) sb_v[i][s] = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin mmem[i][k] = '0; mknown[i][k] = 1'b0; end
    end

    // Reset, then interrupt the clear sweep at cycle 100 and let it restart.
    do_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("rst_busy_a", 32'(busy_a), 32'd1);
    check_eq("rst_busy_c", 32'(busy_c), 32'd0);
    for (int k = 0; k < 100; k++) rand_cycle();
    do_cycle(1'b1, 1'b1, 1'b1, 8'h10, 8'hEE);
    count_busy("busy_len");

    verbose = 1'b1;
    do_cycle(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    check_eq("rd00", {23'd0, valid_a, out_a}, {23'd0, 1'b1, 8'h00});
    do_cycle(1'b0, 1'b1, 1'b0, 8'h7F, 8'h00);
    check_eq("rd7f", {23'd0, valid_a, out_a}, {23'd0, 1'b1, 8'h00});
    do_cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
    check_eq("rdff", {23'd0, valid_a, out_a}, {23'd0, 1'b1, 8'h00});

    do_cycle(1'b0, 1'b1, 1'b1, 8'h10, 8'hA5);
    do_cycle(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    check_eq("a5_lat1", {23'd0, valid_a, out_a}, {23'd0, 1'b1, 8'hA5});
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("a5_hold", {23'd0, valid_a, out_a}, {23'd0, 1'b0, 8'hA5});
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("a5_lat3", {23'd0, valid_b, out_b}, {23'd0, 1'b1, 8'hA5});

    do_cycle(1'b0, 1'b1, 1'b1, 8'h20, 8'h3C);
    do_cycle(1'b0, 1'b1, 1'b1, 8'h20, 8'hC3);
    check_eq("rdw_old", 32'(out_a), 32'h3C);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("rdw_new", 32'(out_b), 32'hC3);

    for (int k = 0; k < 8; k++) do_cycle(1'b0, 1'b1, 1'b1, 8'(k), 8'(k + 1));
    for (int k = 7; k >= 0; k--) begin
      do_cycle(1'b0, 1'b1, 1'b0, 8'(k), 8'h00);
      check_eq("pop", {23'd0, valid_a, out_a}, {23'd0, 1'b1, 8'(k + 1)});
    end
    verbose = 1'b0;

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 999) == 0) do_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      else rand_cycle();
      if (busy_c) busy_c_seen = 1'b1;
    end

    // Contents survive reset when the clear sweep is disabled.
    verbose = 1'b1;
    do_cycle(1'b0, 1'b1, 1'b1, 8'hFF, 8'h5A);
    do_cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    do_cycle(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
    do_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    check_eq("keep_5a", {23'd0, valid_c, out_c}, {23'd0, 1'b1, 8'h5A});
    check_eq("busy_a_after_rst", 32'(busy_a), 32'd1);
    verbose = 1'b0;
    check_eq("busy_c_never", 32'(busy_c_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
